jam_cost_server: RTL

Cost-table responder for the job-assignment engine: stores the 8×8 worker/job cost matrix, answers the engine's W/J lookups with registered Cost, and checks the engine's final MinCost/MatchCount. Sits on the opposite side of the W/J→Cost interface from the engine, with a serial preload port on the host side.

---
 rtl/jam_cost_server.sv | 97 +++++++++
 1 files changed

// File: rtl/jam_cost_server.sv
// Cost-table responder: preloaded 8x8 worker/job cost matrix, W/J lookups, final-result checker.
// Latency: Cost is registered, valid one cycle after {W,J} is sampled; CHK_* update on the Valid edge.
// Backpressure: none; one load word per LD_EN cycle, one lookup per cycle, timeout bounds the serve phase.
module jam_cost_server #(
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LD_EN,
    input  logic [6:0]  LD_DATA,
    output logic        LD_READY,
    input  logic [2:0]  W,
    input  logic [2:0]  J,
    output logic [6:0]  Cost,
    input  logic        Valid,
    input  logic [9:0]  MinCost,
    input  logic [3:0]  MatchCount,
    input  logic [9:0]  EXP_MIN,
    input  logic [3:0]  EXP_CNT,
    output logic [19:0] CYCLES,
    output logic        CHK_DONE,
    output logic        CHK_PASS
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [19:0] CYC_MAX = 20'hFFFFF;

    state_t     state;
    logic [5:0] ptr;
    logic [6:0] mem [64];
    logic       load_we;
    logic [5:0] rd_addr;
    logic       result_ok;

    assign load_we   = (state == ST_LOAD) && LD_EN;
    assign rd_addr   = {W, J};
    assign result_ok = (MinCost == EXP_MIN) && (MatchCount == EXP_CNT);

    // The array itself carries no reset; its contents are only trusted after a full 64-word load.
    always_ff @(posedge CLK) begin
        if (load_we) begin
            mem[ptr] <= LD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_LOAD;
            ptr      <= 6'd0;
            LD_READY <= 1'b0;
            Cost     <= 7'd0;
            CYCLES   <= 20'd0;
            CHK_DONE <= 1'b0;
            CHK_PASS <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    Cost <= 7'd0;
                    if (LD_EN) begin
                        ptr <= ptr + 6'd1;
                        if (ptr == 6'd63) begin
                            LD_READY <= 1'b1;
                            state    <= ST_SERVE;
                        end
                    end
                end
                ST_SERVE: begin
                    Cost <= mem[rd_addr];
                    // Valid takes precedence over the timeout when both land on the same edge.
                    if (Valid) begin
                        CHK_PASS <= result_ok;
                        CHK_DONE <= 1'b1;
                        state    <= ST_DONE;
                    end else if (CYCLES == TIMEOUT) begin
                        CHK_PASS <= 1'b0;
                        CHK_DONE <= 1'b1;
                        state    <= ST_DONE;
                    end else if (CYCLES != CYC_MAX) begin
                        CYCLES <= CYCLES + 20'd1;
                    end
                end
                ST_DONE: begin
                    Cost <= mem[rd_addr];
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
